seq_detect_multi: RTL
=====================

# seq_detect_multi

Parametrised multi-pattern serial sequence detector, generalising the fixed-pattern single-output detector FSMs in this codebase. A single serial bit stream `w`, qualified by `w_vld`, is compared against N independently programmable patterns of up to W bits. Each pattern has its own overlap/non-overlap mode, a one-cycle match pulse and a saturating match counter. The block sits between a serial front end and control logic that needs per-pattern event pulses and statistics.

## Interface
- `W`, default 8: maximum pattern length in bits.
- `N`, default 2: number of pattern channels.
- `CW`, default 8: width of each match counter.
- `LW`, derived, `$clog2(W+1)`: width of a length field.
- `Clk`  in  1  clock; all state updates on its rising edge.
- `Rst`  in  1  reset; synchronous, active-high.
- `w`  in  1  serial data bit.
- `w_vld`  in  1  `w` is sampled only when this is high.
- `cfg_we`  in  1  configuration write strobe.
- `cfg_sel`  in  `max(1,$clog2(N))`  channel selected for the write; values ≥ N are ignored.
- `cfg_pat`  in  W  pattern bits; `pat[len-1]` is the first bit received and `pat[0]` is the last.
- `cfg_len`  in  LW  pattern length; 0 disables the channel; values > W are clamped to W.
- `cfg_ovl`  in  1  1 = overlapping matches, 0 = non-overlapping.
- `clr`  in  1  clears `z_any`.
- `z`  out  N  per-channel match pulse, one cycle wide.
- `z_any`  out  1  sticky flag, set when any channel matches.
- `cnt`  out  N*CW  per-channel match count; channel i occupies `[i*CW +: CW]`.

## Operation
- Shared history register `H[W-1:0]`. On each `w_vld` edge: `H <= {H[W-2:0], w}`, so the newest bit is in `H[0]`. `Hn` is the combinational next-history value.
- Each channel runs an FSM with states DISABLED, FILLING and ARMED. It holds `pat`, `len`, `ovl` and a fill count `f` (0..W).
- DISABLED: entered when `len == 0`. The channel never matches and `f` stays 0.
- FILLING: on `w_vld`, `f <= f + 1`. When `f + 1 == len`, evaluate the match against `Hn` and go to ARMED, unless a non-overlap match occurs, in which case `f <= 0` and the channel stays in FILLING.
- ARMED: on each `w_vld`, a match is `Hn[len-1:0] == pat[len-1:0]`.
  - Non-overlap match: `f <= 0`, go to FILLING.
  - Otherwise: stay in ARMED.
- On a match:
  - `z[i] <= 1` for one cycle.
  - `cnt_i <= cnt_i + 1`, saturating at all-ones.
  - `z_any <= 1`.
- `z` is 0 in every cycle that does not follow a matching `w_vld` edge.
- Config write to channel i:
  - Loads `pat`, `len` (clamped) and `ovl`.
  - Sets `f <= 0`. State becomes FILLING, or DISABLED if `len == 0`.
  - Suppresses any match on channel i in that cycle.
  - Does not clear `cnt_i`.
- Simultaneous `cfg_we` and `w_vld`:
  - The bit still shifts into `H`.
  - Channel i does not count that bit.
  - All other channels process it normally.
- `clr` and a match in the same cycle: the set wins, so `z_any` stays 1.
- Reset values: `H`=0, all `pat`/`len`/`ovl`/`f`=0, all channels DISABLED, `z`=0, `z_any`=0, `cnt`=0. `Rst` overrides every other input in the same cycle, including mid-pattern.

## Timing
- Latency is 1 clock. The bit sampled at edge k produces `z`/`cnt`/`z_any` updates at edge k, visible in the following cycle.
- Back-to-back `w_vld` is supported at one bit per clock. Gaps with `w_vld` low change no state.
- In overlap mode a channel can match on consecutive bits (e.g. `111` on a run of 1s), producing a `z` pulse every cycle.
- A config write takes effect at its edge. The next `w_vld` bit is the first counted bit.

## Structure
- Package `seq_det_pkg` contains:
  - The `chan_state_t` enum (DISABLED, FILLING, ARMED).
  - The width helper `lw(W)`.
  - The length-clamp function.
- Sub-module `seq_det_chan` contains the per-channel config registers, FSM, fill counter, comparator and saturating counter.
  - Inputs: `Hn`, `w_vld`, and that channel's decoded write strobe.
  - Output: that channel's match and count.
- The top level instantiates `seq_det_chan` N times and owns the history register, `cfg_sel` decode and `z_any`.

## Test plan
- **Non-overlap:** reset; write ch0 `pat=1001`, `len=4`, `ovl=0`; send `1,0,0,1,0,0,1` back-to-back. Expect `z[0]` to pulse once, after bit 4, and `cnt0=1` at the end.
- **Overlap:** same stream with `ovl=1`. Expect `z[0]` pulses after bits 4 and 7 and `cnt0=2`. `z_any` rises after bit 4.
- **Independent channels:** ch1 `pat=111`, `len=3`, `ovl=1`, ch0 as in the first case; send five 1s. Expect `z[1]` after bits 3, 4 and 5 with `cnt1=3`. Expect `z[0]` never asserts.
- **`w_vld` gaps:** 1–3 idle cycles between every bit of the first case. Match positions are unchanged, and `z` is never high except in the cycle after a valid bit.
- **Saturation and `clr`:** `CW=2`, `111` overlap, ten 1s. Expect `cnt1` to stick at 3 while `z[1]` keeps pulsing. `clr` coinciding with a match leaves `z_any=1`; `clr` alone gives `z_any=0` next cycle.
- **Reset and config mid-stream:**
  - Reset after `1,0,0` of `1001`: all outputs are 0, channels are DISABLED, and a following `1` produces no match.
  - Separately, rewrite ch0 in the same cycle as bit 4 of `1001`: no `z[0]` pulse.

Source files
------------

// File: rtl/seq_det_pkg.sv
// ---------------------------------------------------------------------------
// seq_det_pkg
// Shared types and helpers for the multi-pattern serial sequence detector.
//   chan_state_t : per-channel FSM state
//   lw()         : width of a length field able to hold 0..W
//   clamp_len()  : limits a programmed length to the history depth
// ---------------------------------------------------------------------------
package seq_det_pkg;

   typedef enum logic [1:0] {
      DISABLED = 2'd0,
      FILLING  = 2'd1,
      ARMED    = 2'd2
   } chan_state_t;

   function automatic int lw(input int w);
      return $clog2(w + 1);
   endfunction

   function automatic int clamp_len(input int len, input int w);
      return (len > w) ? w : len;
   endfunction

endpackage

// File: rtl/seq_det_chan.sv
// ---------------------------------------------------------------------------
// seq_det_chan
// One pattern channel: config registers, DISABLED/FILLING/ARMED FSM, fill
// counter, masked comparator against the next-history value and a
// saturating match counter.
// Ports:
//   Clk, Rst  : clock, synchronous active-high reset
//   i_we      : decoded config write strobe for this channel
//   i_pat     : pattern, i_pat[len-1] is the oldest bit
//   i_len     : pattern length (0 disables, clamped to W)
//   i_ovl     : 1 = overlapping matches
//   i_vld     : serial bit valid
//   i_hn      : next history value (newest bit in [0])
//   o_hit     : combinational match this cycle (feeds the sticky flag)
//   o_z       : registered one-cycle match pulse
//   o_cnt     : saturating match count
// ---------------------------------------------------------------------------
module seq_det_chan
   import seq_det_pkg::*;
#(
   parameter int W  = 8,
   parameter int CW = 8,
   parameter int LW = lw(W)
) (
   input  logic          Clk,
   input  logic          Rst,
   input  logic          i_we,
   input  logic [W-1:0]  i_pat,
   input  logic [LW-1:0] i_len,
   input  logic          i_ovl,
   input  logic          i_vld,
   input  logic [W-1:0]  i_hn,
   output logic          o_hit,
   output logic          o_z,
   output logic [CW-1:0] o_cnt
);

   chan_state_t   r_state;
   logic [W-1:0]  r_pat;
   logic [LW-1:0] r_len;
   logic          r_ovl;
   logic [LW-1:0] r_f;
   logic          r_z;
   logic [CW-1:0] r_cnt;

   logic [W-1:0]  w_mask;
   logic [LW-1:0] w_len_c;
   logic [LW-1:0] w_f_inc;
   logic          w_eq;
   logic          w_eval;

   assign w_len_c = LW'(clamp_len(int'(i_len), W));
   assign w_f_inc = r_f + LW'(1);

   // Only the low len bits of the history take part in the compare.
   always_comb begin
      w_mask = '0;
      for (int i = 0; i < W; i++) w_mask[i] = (i < int'(r_len));
   end

   assign w_eq   = (((i_hn ^ r_pat) & w_mask) == '0);
   // FILLING evaluates only on the bit that completes the window.
   assign w_eval = (r_state == ARMED) ||
                   ((r_state == FILLING) && (w_f_inc == r_len));
   // A config write in the same cycle masks any match on this channel.
   assign o_hit  = i_vld & ~i_we & w_eval & w_eq;

   always_ff @(posedge Clk) begin
      if (Rst) begin
         r_state <= DISABLED;
         r_pat   <= '0;
         r_len   <= '0;
         r_ovl   <= 1'b0;
         r_f     <= '0;
         r_z     <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_z <= o_hit;
         if (o_hit && (r_cnt != '1)) r_cnt <= r_cnt + 1'b1;
         if (i_we) begin
            r_pat   <= i_pat;
            r_len   <= w_len_c;
            r_ovl   <= i_ovl;
            r_f     <= '0;
            r_state <= (w_len_c == '0) ? DISABLED : FILLING;
         end else if (i_vld) begin
            case (r_state)
               FILLING: begin
                  if (w_eval && o_hit && !r_ovl) begin
                     r_f <= '0;
                  end else begin
                     r_f <= w_f_inc;
                     if (w_eval) r_state <= ARMED;
                  end
               end
               ARMED: begin
                  if (o_hit && !r_ovl) begin
                     r_f     <= '0;
                     r_state <= FILLING;
                  end
               end
               default: r_f <= '0;
            endcase
         end
      end
   end

   assign o_z   = r_z;
   assign o_cnt = r_cnt;

endmodule

// File: rtl/seq_detect_multi.sv
// ---------------------------------------------------------------------------
// seq_detect_multi
// Multi-pattern serial sequence detector. One serial stream is shifted into
// a shared history register and compared by N independent channels.
// Ports:
//   Clk, Rst   : clock, synchronous active-high reset
//   w, w_vld   : serial bit and its qualifier
//   cfg_*      : channel configuration write (sel >= N ignored)
//   clr        : clears the sticky z_any flag (a same-cycle match wins)
//   z          : per-channel one-cycle match pulse
//   z_any      : sticky any-match flag
//   cnt        : per-channel saturating counts, channel i at [i*CW +: CW]
// ---------------------------------------------------------------------------
module seq_detect_multi
   import seq_det_pkg::*;
#(
   parameter  int W  = 8,
   parameter  int N  = 2,
   parameter  int CW = 8,
   localparam int LW = lw(W),
   localparam int SW = (N > 1) ? $clog2(N) : 1
) (
   input  logic            Clk,
   input  logic            Rst,
   input  logic            w,
   input  logic            w_vld,
   input  logic            cfg_we,
   input  logic [SW-1:0]   cfg_sel,
   input  logic [W-1:0]    cfg_pat,
   input  logic [LW-1:0]   cfg_len,
   input  logic            cfg_ovl,
   input  logic            clr,
   output logic [N-1:0]    z,
   output logic            z_any,
   output logic [N*CW-1:0] cnt
);

   logic [W-1:0]          r_hist;
   logic                  r_z_any;
   logic [W-1:0]          w_hn;
   logic [N-1:0]          w_we;
   logic [N-1:0]          w_hit;
   logic [N-1:0][CW-1:0]  w_cnt;

   assign w_hn = {r_hist[W-2:0], w};

   for (genvar g = 0; g < N; g++) begin : g_chan
      assign w_we[g] = cfg_we && (cfg_sel == SW'(g));
      seq_det_chan #(.W(W), .CW(CW), .LW(LW)) u_chan (
         .Clk   (Clk),
         .Rst   (Rst),
         .i_we  (w_we[g]),
         .i_pat (cfg_pat),
         .i_len (cfg_len),
         .i_ovl (cfg_ovl),
         .i_vld (w_vld),
         .i_hn  (w_hn),
         .o_hit (w_hit[g]),
         .o_z   (z[g]),
         .o_cnt (w_cnt[g])
      );
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         r_hist  <= '0;
         r_z_any <= 1'b0;
      end else begin
         if (w_vld) r_hist <= w_hn;
         r_z_any <= (|w_hit) | (r_z_any & ~clr);
      end
   end

   assign z_any = r_z_any;
   assign cnt   = w_cnt;

endmodule
